ov7670_capture: RTL and testbench

//   Receive side of the OV7670 camera interface. It samples PCLK/VSYNC/HREF/D[7:0] from the sensor
//   (or camera_simulator in simulation) and packs RGB565 byte pairs into 16-bit pixels.
//   It emits one frame-buffer write per pixel with a linear address.

---
 rtl/ov7670_capture_pkg.sv | 30 +++
 rtl/ov7670_byte_pack.sv | 34 +++
 rtl/ov7670_capture.sv | 147 ++++++++++++++
 tb/tb_ov7670_capture.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_capture_pkg.sv
// rtl/ov7670_capture_pkg.sv - shared constants, FSM states and RGB565 field helpers for OV7670 capture
package ov7670_capture_pkg;

  // Common sensor resolutions
  localparam int VGA_H_ACTIVE  = 640;
  localparam int VGA_V_ACTIVE  = 480;
  localparam int QVGA_H_ACTIVE = 320;
  localparam int QVGA_V_ACTIVE = 240;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_SYNC    = 2'd2,
    ST_ACTIVE  = 2'd3
  } cap_state_t;

  // RGB565 field extraction
  function automatic logic [4:0] rgb565_red(input logic [15:0] p);
    return p[15:11];
  endfunction

  function automatic logic [5:0] rgb565_green(input logic [15:0] p);
    return p[10:5];
  endfunction

  function automatic logic [4:0] rgb565_blue(input logic [15:0] p);
    return p[4:0];
  endfunction

endpackage

// File: rtl/ov7670_byte_pack.sv
// rtl/ov7670_byte_pack.sv - pairs consecutive line bytes into 16-bit RGB565 pixels
module ov7670_byte_pack
  import ov7670_capture_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        hr,
  input  logic [7:0]  d,
  output logic        pix_valid,
  output logic [15:0] pix
);

  logic       phase;
  logic [7:0] hi;

  // Toggle phase per byte while the line is valid; hold the first byte of each pair
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 1'b0;
      hi    <= 8'd0;
    end else if (en && hr) begin
      phase <= ~phase;
      if (!phase) hi <= d;
    end else begin
      phase <= 1'b0;
    end
  end

  // Second byte of a pair completes the pixel in the same cycle
  assign pix_valid = en & hr & phase;
  assign pix       = {hi, d};

endmodule

// File: rtl/ov7670_capture.sv
// rtl/ov7670_capture.sv - OV7670 frame capture: sync FSM, pixel addressing and frame-buffer writes
module ov7670_capture
  import ov7670_capture_pkg::*;
#(
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int ADDR_WIDTH = 19
) (
  input  logic                  ov7670_pclk,
  input  logic                  rst_n,
  input  logic                  ov7670_vsync,
  input  logic                  ov7670_href,
  input  logic [7:0]            ov7670_data,
  input  logic                  enable,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [15:0]           pixel,
  output logic                  frame_done,
  output logic [7:0]            frame_count,
  output logic                  overflow
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0]         X_LIM     = XW'(H_ACTIVE);
  localparam logic [YW-1:0]         Y_LIM     = YW'(V_ACTIVE);
  localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(H_ACTIVE);

  logic                  vs_r, hr_r, vs_q, hr_q;
  logic [7:0]            d_r;
  cap_state_t            state, state_nxt;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic [ADDR_WIDTH-1:0] line_base;
  logic                  line_seen;
  logic                  vs_rise, vs_fall, hr_fall;
  logic                  in_active, pack_en, frame_start, frame_end, in_window;
  logic                  pix_fire;
  logic [15:0]           pix;

  // Register the sensor pins once, plus one more stage of vsync/href for edge detection
  always_ff @(posedge ov7670_pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_r <= 1'b0;
      hr_r <= 1'b0;
      d_r  <= 8'd0;
      vs_q <= 1'b0;
      hr_q <= 1'b0;
    end else begin
      vs_r <= ov7670_vsync;
      hr_r <= ov7670_href;
      d_r  <= ov7670_data;
      vs_q <= vs_r;
      hr_q <= hr_r;
    end
  end

  assign vs_rise     = vs_r & ~vs_q;
  assign vs_fall     = ~vs_r & vs_q;
  assign hr_fall     = hr_q & ~hr_r;
  assign in_active   = (state == ST_ACTIVE);
  // A vsync rise ends the frame at once, so a half-built pixel on that cycle is dropped
  assign pack_en     = in_active & ~vs_rise;
  assign frame_start = (state == ST_SYNC) & vs_fall;
  assign frame_end   = in_active & vs_rise;
  assign in_window   = (x < X_LIM) && (y < Y_LIM);

  ov7670_byte_pack u_pack (
    .clk       (ov7670_pclk),
    .rst_n     (rst_n),
    .en        (pack_en),
    .hr        (hr_r),
    .d         (d_r),
    .pix_valid (pix_fire),
    .pix       (pix)
  );

  // FSM state register
  always_ff @(posedge ov7670_pclk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state; enable only matters when idle or at the end of a captured frame
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (enable)  state_nxt = ST_WAIT_VS;
      ST_WAIT_VS: if (vs_rise) state_nxt = ST_SYNC;
      ST_SYNC:    if (vs_fall) state_nxt = ST_ACTIVE;
      ST_ACTIVE:  if (vs_rise) state_nxt = enable ? ST_SYNC : ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Pixel/line position; line_base steps by an add so no multiplier is needed
  always_ff @(posedge ov7670_pclk or negedge rst_n) begin
    if (!rst_n) begin
      x         <= '0;
      y         <= '0;
      line_base <= '0;
      line_seen <= 1'b0;
    end else if (frame_start) begin
      x         <= '0;
      y         <= '0;
      line_base <= '0;
      line_seen <= 1'b0;
    end else if (in_active) begin
      if (pix_fire && (x < X_LIM)) x <= x + 1'b1;
      if (hr_r) begin
        line_seen <= 1'b1;
      end else begin
        line_seen <= 1'b0;
        if (hr_fall && line_seen) begin
          x <= '0;
          if (y < Y_LIM) begin
            y         <= y + 1'b1;
            line_base <= line_base + LINE_STEP;
          end
        end
      end
    end
  end

  // Frame-buffer write port, frame counter and sticky clip flag
  always_ff @(posedge ov7670_pclk or negedge rst_n) begin
    if (!rst_n) begin
      we          <= 1'b0;
      addr        <= '0;
      pixel       <= 16'd0;
      frame_done  <= 1'b0;
      frame_count <= 8'd0;
      overflow    <= 1'b0;
    end else begin
      we         <= pix_fire & in_window;
      frame_done <= frame_end;
      if (frame_end) frame_count <= frame_count + 8'd1;
      if (pix_fire && in_window) begin
        addr  <= line_base + ADDR_WIDTH'(x);
        pixel <= pix;
      end
      if (frame_start)                 overflow <= 1'b0;
      else if (pix_fire && !in_window) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ov7670_capture.sv
// tb/tb_ov7670_capture.sv - directed self-checking bench for ov7670_capture at 4x3 resolution
module tb_ov7670_capture;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vsync, href, enable;
  logic [7:0]    data;
  logic          we, frame_done, overflow;
  logic [AW-1:0] addr;
  logic [15:0]   pixel;
  logic [7:0]    frame_count;

  int checks = 0;
  int errors = 0;
  int addr_log[$];
  int pix_log[$];
  int done_cnt = 0;

  ov7670_capture #(.H_ACTIVE(4), .V_ACTIVE(3), .ADDR_WIDTH(AW)) dut (
    .ov7670_pclk  (clk),
    .rst_n        (rst_n),
    .ov7670_vsync (vsync),
    .ov7670_href  (href),
    .ov7670_data  (data),
    .enable       (enable),
    .we           (we),
    .addr         (addr),
    .pixel        (pixel),
    .frame_done   (frame_done),
    .frame_count  (frame_count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  // Record writes and frame_done pulses away from the rising edge
  always @(negedge clk) begin
    if (we) begin
      addr_log.push_back(int'(addr));
      pix_log.push_back(int'(pixel));
    end
    if (frame_done) done_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    addr_log.delete();
    pix_log.delete();
  endtask

  task automatic vs_pulse();
    vsync = 1'b1;
    tick(3);
    vsync = 1'b0;
    tick(3);
  endtask

  task automatic send_line(input int n, input int start);
    for (int i = 0; i < n; i++) begin
      href = 1'b1;
      data = 8'(start + i);
      tick();
    end
    href = 1'b0;
    tick(3);
  endtask

  function automatic int log_at(input int idx, input bit is_addr);
    if (idx >= addr_log.size()) return -1;
    return is_addr ? addr_log[idx] : pix_log[idx];
  endfunction

  initial begin
    int bad;
    rst_n = 1'b0; vsync = 1'b0; href = 1'b0; enable = 1'b0; data = 8'd0;
    tick(2);
    chk("rst_we", int'(we), 0);
    chk("rst_addr", int'(addr), 0);
    chk("rst_frame_count", int'(frame_count), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    rst_n = 1'b1;
    enable = 1'b1;
    tick(2);

    // 1: full 4x3 frame with bytes 0x00..0x17
    vs_pulse();
    clear_log();
    for (int l = 0; l < 3; l++) send_line(8, l * 8);
    chk("t1_writes", addr_log.size(), 12);
    bad = 0;
    for (int k = 0; k < 12; k++)
      if (log_at(k, 1) != k || log_at(k, 0) != ((2 * k) << 8 | (2 * k + 1))) bad++;
    chk("t1_sequence", bad, 0);
    chk("t1_first_pixel", log_at(0, 0), 16'h0001);
    chk("t1_last_pixel", log_at(11, 0), 16'h1617);
    vs_pulse();
    chk("t1_done_pulses", done_cnt, 1);
    chk("t1_frame_count", int'(frame_count), 1);
    chk("t1_overflow", int'(overflow), 0);

    // 2: a 10-byte line clips its 5th pixel; next line still starts at addr 4
    clear_log();
    send_line(10, 8'h20);
    send_line(8, 8'h40);
    chk("t2_writes", addr_log.size(), 8);
    chk("t2_clip_last", log_at(3, 0), 16'h2627);
    chk("t2_next_addr", log_at(4, 1), 4);
    chk("t2_next_pixel", log_at(4, 0), 16'h4041);
    chk("t2_overflow_set", int'(overflow), 1);
    vs_pulse();
    chk("t2_overflow_clr", int'(overflow), 0);
    chk("t2_frame_count", int'(frame_count), 2);

    // 3: odd 7-byte line drops its dangling byte
    clear_log();
    send_line(7, 8'h50);
    send_line(8, 8'h60);
    chk("t3_writes", addr_log.size(), 7);
    chk("t3_pix2", log_at(2, 0), 16'h5455);
    chk("t3_next_addr", log_at(3, 1), 4);
    chk("t3_next_pixel", log_at(3, 0), 16'h6061);
    chk("t3_overflow", int'(overflow), 0);

    // 4a: enable dropped mid-frame; frame completes then capture stops
    enable = 1'b0;
    send_line(8, 8'h70);
    chk("t4_last_addr", log_at(10, 1), 11);
    chk("t4_last_pixel", log_at(10, 0), 16'h7677);
    vs_pulse();
    send_line(8, 8'h80);
    vs_pulse();
    send_line(8, 8'h88);
    chk("t4_idle_writes", addr_log.size(), 11);
    chk("t4_frame_count", int'(frame_count), 3);
    chk("t4_done_pulses", done_cnt, 3);

    // 4b: enable raised mid-frame; nothing until after a vsync high->low
    enable = 1'b1;
    send_line(8, 8'h90);
    chk("t4_wait_writes", addr_log.size(), 11);
    vs_pulse();
    send_line(8, 8'hA0);
    chk("t4_resume_writes", addr_log.size(), 15);
    chk("t4_resume_addr", log_at(11, 1), 0);
    chk("t4_resume_pixel", log_at(11, 0), 16'hA0A1);
    chk("t4_resume_count", int'(frame_count), 3);

    // 5: reset during a line clears outputs at once; partial frame ignored
    for (int i = 0; i < 5; i++) begin
      href = 1'b1;
      data = 8'(8'hB0 + i);
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_we", int'(we), 0);
    chk("t5_async_addr", int'(addr), 0);
    chk("t5_async_count", int'(frame_count), 0);
    tick(2);
    rst_n = 1'b1;
    clear_log();
    done_cnt = 0;
    for (int i = 5; i < 8; i++) begin
      data = 8'(8'hB0 + i);
      tick();
    end
    href = 1'b0;
    tick(3);
    send_line(8, 8'hB8);
    chk("t5_partial_writes", addr_log.size(), 0);
    vs_pulse();
    for (int l = 0; l < 3; l++) send_line(8, 8'hC0 + l * 8);
    chk("t5_writes", addr_log.size(), 12);
    chk("t5_first_addr", log_at(0, 1), 0);
    chk("t5_first_pixel", log_at(0, 0), 16'hC0C1);
    chk("t5_last_addr", log_at(11, 1), 11);
    chk("t5_last_pixel", log_at(11, 0), 16'hD6D7);

    // 6: 257 frames of 4 lines; counter wraps, extra line sets overflow
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    done_cnt = 0;
    tick(2);
    vs_pulse();
    for (int f = 0; f < 257; f++) begin
      if (f == 256) clear_log();
      for (int l = 0; l < 4; l++) send_line(8, l * 8);
      if (f == 256) begin
        chk("t6_writes", addr_log.size(), 12);
        chk("t6_overflow", int'(overflow), 1);
        chk("t6_last_addr", log_at(11, 1), 11);
      end
      vs_pulse();
    end
    chk("t6_frame_count", int'(frame_count), 1);
    chk("t6_done_pulses", done_cnt, 257);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
